// File: rtl/tx_upconv.sv
// tx_upconv: NCO-driven complex-to-real upconverter, out = sat(round((I*cos - Q*sin) / 2^(DSZ-1))).
// Latency: out/out_valid update 5 cycles after the clock edge that captures an in_valid sample.
// Backpressure: none; a new sample is accepted every cycle and results are never stalled or dropped.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   i_in, q_in         signed baseband sample, qualified by in_valid
//   frq_in, frq_ld     phase step per sample, loaded into the active register on frq_ld
//   phs_clr            zeroes the NCO phase state (wins over a coincident in_valid)
//   ns_ena             selects noise-shaped phase truncation for the table address
//   out, out_valid     signed real output sample and its one-cycle qualifier
module tx_upconv #(
    parameter int DSZ = 14,
    parameter int FSZ = 26,
    parameter int PSZ = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [DSZ-1:0] i_in,
    input  logic signed [DSZ-1:0] q_in,
    input  logic                  in_valid,
    input  logic        [FSZ-1:0] frq_in,
    input  logic                  frq_ld,
    input  logic                  phs_clr,
    input  logic                  ns_ena,
    output logic signed [DSZ-1:0] out,
    output logic                  out_valid
);

    localparam int  ESZ    = FSZ - PSZ;      // phase bits dropped by truncation
    localparam int  TBL    = 2**PSZ;         // sinusoid table depth
    localparam int  PW     = 2*DSZ;          // full-precision product width
    localparam int  SW     = 2*DSZ + 1;      // product difference plus rounding term
    localparam real TWO_PI = 6.283185307179586;
    localparam real AMP    = real'(2**(DSZ-1) - 1);

    localparam logic signed [SW-1:0] RND    = SW'(2**(DSZ-2));
    localparam logic signed [SW-1:0] SAT_HI = SW'(2**(DSZ-1) - 1);
    localparam logic signed [SW-1:0] SAT_LO = -SW'(2**(DSZ-1));

    // Table entry: round-half-away-from-zero of AMP*cos/sin. Evaluated only with
    // constant arguments, so the table folds to a ROM at elaboration.
    function automatic logic signed [DSZ-1:0] tbl_val(input int p, input bit want_sin);
        real ang;
        real f;
        ang = TWO_PI * real'(p) / real'(TBL);
        f   = want_sin ? AMP * $sin(ang) : AMP * $cos(ang);
        if (f >= 0.0)
            return DSZ'($rtoi(f + 0.5));
        else
            return DSZ'(-$rtoi(0.5 - f));
    endfunction

    logic signed [DSZ-1:0] cos_rom [TBL];
    logic signed [DSZ-1:0] sin_rom [TBL];

    for (genvar g = 0; g < TBL; g++) begin : g_rom
        assign cos_rom[g] = tbl_val(g, 1'b0);
        assign sin_rom[g] = tbl_val(g, 1'b1);
    end

    // ------------------------------------------------------------------
    // NCO
    // ------------------------------------------------------------------
    logic [FSZ-1:0] frq;
    logic [FSZ-1:0] acc;
    logic [FSZ-1:0] ns_acc;
    logic [FSZ-1:0] ns_err;
    logic [PSZ-1:0] phs_sel;

    // Low bits of the shaped accumulator, read as a signed residue, are fed
    // back onto the next phase.
    assign ns_err  = {{PSZ{ns_acc[ESZ-1]}}, ns_acc[ESZ-1:0]};
    assign phs_sel = ns_ena ? ns_acc[FSZ-1 -: PSZ] : acc[FSZ-1 -: PSZ];

    always_ff @(posedge clk) begin
        if (reset) begin
            frq    <= '0;
            acc    <= '0;
            ns_acc <= '0;
        end else begin
            // A sample in the same cycle as frq_ld still steps by the old value.
            if (frq_ld)
                frq <= frq_in;

            if (phs_clr) begin
                // Coincident sample is taken at phase 0, so acc lands one step on.
                acc    <= in_valid ? frq : '0;
                ns_acc <= '0;
            end else if (in_valid) begin
                acc <= acc + frq;
                if (ns_ena)
                    ns_acc <= acc + ns_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: capture -> table -> products -> sum -> saturate -> out
    // ------------------------------------------------------------------
    logic                  s1_vld, s2_vld, s3_vld, s4_vld, s5_vld;
    logic signed [DSZ-1:0] s1_i, s1_q, s2_i, s2_q;
    logic        [PSZ-1:0] s1_phs;
    logic signed [DSZ-1:0] s2_cos, s2_sin;
    logic signed [PW-1:0]  s3_pc, s3_ps;
    logic signed [SW-1:0]  s4_sum;
    logic signed [SW-1:0]  shf;
    logic signed [DSZ-1:0] sat;
    logic signed [DSZ-1:0] s5_dat;

    always_comb begin
        shf = s4_sum >>> (DSZ-1);
        sat = shf[DSZ-1:0];
        if (shf > SAT_HI)
            sat = SAT_HI[DSZ-1:0];
        else if (shf < SAT_LO)
            sat = SAT_LO[DSZ-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s3_vld    <= 1'b0;
            s4_vld    <= 1'b0;
            s5_vld    <= 1'b0;
            out_valid <= 1'b0;
            s1_i      <= '0;
            s1_q      <= '0;
            s1_phs    <= '0;
            s2_i      <= '0;
            s2_q      <= '0;
            s2_cos    <= '0;
            s2_sin    <= '0;
            s3_pc     <= '0;
            s3_ps     <= '0;
            s4_sum    <= '0;
            s5_dat    <= '0;
            out       <= '0;
        end else begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_i   <= i_in;
                s1_q   <= q_in;
                s1_phs <= phs_clr ? '0 : phs_sel;
            end

            s2_vld <= s1_vld;
            s2_i   <= s1_i;
            s2_q   <= s1_q;
            s2_cos <= cos_rom[s1_phs];
            s2_sin <= sin_rom[s1_phs];

            s3_vld <= s2_vld;
            s3_pc  <= PW'(s2_i) * PW'(s2_cos);
            s3_ps  <= PW'(s2_q) * PW'(s2_sin);

            s4_vld <= s3_vld;
            s4_sum <= SW'(s3_pc) - SW'(s3_ps) + RND;

            s5_vld <= s4_vld;
            s5_dat <= sat;

            // Output register only moves on a valid result, so it holds between pulses.
            out_valid <= s5_vld;
            if (s5_vld)
                out <= s5_dat;
        end
    end

endmodule
